// File: rtl/sync_pkg.sv
// Shared definitions for clock-domain-crossing blocks: minimum legal parameters,
// a constant clog2 helper and elaboration-time parameter checks.
`ifndef SYNC_PKG_MACROS
`define SYNC_PKG_MACROS
// Raises an elaboration error when a parameter is below its minimum legal value.
`define SYNC_CHECK_MIN(label, value, minimum, name) \
    if ((value) < (minimum)) begin : label \
        $error("%s = %0d is below the minimum of %0d", name, (value), (minimum)); \
    end
`endif

package sync_pkg;

    localparam int SYNC_MIN_STAGES     = 2;
    localparam int SYNC_MIN_FILTER_LEN = 1;
    localparam int SYNC_MIN_WIDTH      = 1;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: flip-flop synchronizer, stability filter on the synchronized level,
// and registered one-cycle rise/fall event pulses.
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 3,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk_dst,
    input  logic rst,
    input  logic signal_src,
    output logic sync_raw,
    output logic signal_dst,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W    = clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    `SYNC_CHECK_MIN(g_chk_stages, STAGES, SYNC_MIN_STAGES, "STAGES")
    `SYNC_CHECK_MIN(g_chk_filter_len, FILTER_LEN, SYNC_MIN_FILTER_LEN, "FILTER_LEN")

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [CNT_W-1:0] cnt;

    // Pure shift chain: bit 0 is the only flop that sees the asynchronous input.
    always_ff @(posedge clk_dst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], signal_src};
        end
    end

    assign sync_raw = sync_q[STAGES-1];

    // A sample matching the current output restarts the count, so chatter never accumulates.
    always_ff @(posedge clk_dst) begin
        if (rst) begin
            signal_dst <= RESET_VAL;
            cnt        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (sync_raw == signal_dst) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                signal_dst <= sync_raw;
                cnt        <= '0;
                rise_pulse <= sync_raw;
                fall_pulse <= ~sync_raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_filter_multi.sv
// Multi-channel synchronizer and glitch filter: WIDTH independent copies of
// sync_filter_ch, each with its own reset value.
module sync_filter_multi
    import sync_pkg::*;
#(
    parameter int             WIDTH      = 4,
    parameter int             STAGES     = 2,
    parameter int             FILTER_LEN = 3,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk_dst,
    input  logic             rst,
    input  logic [WIDTH-1:0] signal_src,
    output logic [WIDTH-1:0] sync_raw,
    output logic [WIDTH-1:0] signal_dst,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    `SYNC_CHECK_MIN(g_chk_width, WIDTH, SYNC_MIN_WIDTH, "WIDTH")

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_filter_ch #(
            .STAGES     (STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RESET_VAL  (RESET_VAL[i])
        ) u_ch (
            .clk_dst    (clk_dst),
            .rst        (rst),
            .signal_src (signal_src[i]),
            .sync_raw   (sync_raw[i]),
            .signal_dst (signal_dst[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_sync_filter_multi.sv
// Directed bench for sync_filter_multi: every edge is scored against a sliding-window
// model of the filter, plus directed timing checks for each scenario.
module tb_sync_filter_multi;

    localparam int W  = 4;
    localparam int ST = 2;
    localparam int FL = 3;
    localparam logic [W-1:0] RV = '0;

    logic         clk_dst;
    logic         rst;
    logic [W-1:0] signal_src;
    logic [W-1:0] sync_raw;
    logic [W-1:0] signal_dst;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;

    sync_filter_multi #(
        .WIDTH      (W),
        .STAGES     (ST),
        .FILTER_LEN (FL),
        .RESET_VAL  (RV)
    ) dut (
        .clk_dst    (clk_dst),
        .rst        (rst),
        .signal_src (signal_src),
        .sync_raw   (sync_raw),
        .signal_dst (signal_dst),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // Clock / reset block
    initial begin
        clk_dst    = 1'b0;
        rst        = 1'b1;
        signal_src = '0;
    end
    always #5 clk_dst = ~clk_dst;

    // Scoreboard state
    logic [4*W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model: output flips when the last FL synchronized samples all differ from it.
    logic [W-1:0] m_s    [ST];
    logic [W-1:0] m_hist [FL];
    logic [W-1:0] m_dst, m_rise, m_fall;

    // Per-scenario observation log
    int rise_cnt  [W];
    int fall_cnt  [W];
    int raw_hi    [W];
    int last_rise [W];
    int last_fall [W];
    logic [W-1:0] first_rise_vec, first_fall_vec;
    bit seen_pulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [W-1:0] src, input logic r);
        logic all_diff;
        if (r) begin
            for (int k = 0; k < ST; k++) m_s[k] = RV;
            for (int j = 0; j < FL; j++) m_hist[j] = RV;
            m_dst  = RV;
            m_rise = '0;
            m_fall = '0;
        end else begin
            for (int j = FL - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = m_s[ST-1];
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < FL; j++) begin
                    if (m_hist[j][b] == m_dst[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_dst[b] = ~m_dst[b];
                    if (m_dst[b]) m_rise[b] = 1'b1;
                    else          m_fall[b] = 1'b1;
                end
            end
            for (int k = ST - 1; k > 0; k--) m_s[k] = m_s[k-1];
            m_s[0] = src;
        end
    endtask

    task automatic clear_log();
        for (int b = 0; b < W; b++) begin
            rise_cnt[b]  = 0;
            fall_cnt[b]  = 0;
            raw_hi[b]    = 0;
            last_rise[b] = -1;
            last_fall[b] = -1;
        end
        first_rise_vec = '0;
        first_fall_vec = '0;
        seen_pulse     = 1'b0;
    endtask

    // Driver: apply one edge of stimulus, score the outputs #1 after that edge.
    task automatic cycle(input logic [W-1:0] src, input logic r);
        logic [4*W-1:0] obs, exp;
        signal_src = src;
        rst        = r;
        model_step(src, r);
        exp_q.push_back({m_s[ST-1], m_dst, m_rise, m_fall});
        @(posedge clk_dst);
        edge_n++;
        #1;
        obs = {sync_raw, signal_dst, rise_pulse, fall_pulse};
        if (exp_q.size() == 0) begin
            check("sb_queue_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("sb_raw_dst_rise_fall", 32'(obs), 32'(exp));
        end
        for (int b = 0; b < W; b++) begin
            if (rise_pulse[b]) begin rise_cnt[b]++; last_rise[b] = edge_n; end
            if (fall_pulse[b]) begin fall_cnt[b]++; last_fall[b] = edge_n; end
            if (sync_raw[b])   raw_hi[b]++;
        end
        if (!seen_pulse && ((rise_pulse | fall_pulse) != '0)) begin
            seen_pulse     = 1'b1;
            first_rise_vec = rise_pulse;
            first_fall_vec = fall_pulse;
        end
    endtask

    task automatic hold(input logic [W-1:0] src, input int n);
        for (int i = 0; i < n; i++) cycle(src, 1'b0);
    endtask

    int rel_edge;
    int run_edge;
    int base_edge;

    initial begin
        for (int k = 0; k < ST; k++) m_s[k] = RV;
        for (int j = 0; j < FL; j++) m_hist[j] = RV;
        m_dst  = RV;
        m_rise = '0;
        m_fall = '0;
        clear_log();

        // Reset with all inputs high: outputs held at reset value.
        for (int i = 0; i < 3; i++) cycle(4'hF, 1'b1);
        check("reset_outputs", 32'({sync_raw, signal_dst, rise_pulse, fall_pulse}), 32'd0);
        clear_log();
        cycle(4'hF, 1'b0);
        rel_edge = edge_n;
        hold(4'hF, 6);
        check("reset_release_latency", 32'(last_rise[0] - rel_edge + 1), 32'd5);
        check("reset_release_rise_vec", 32'(first_rise_vec), 32'hF);
        check("reset_release_rise_once", 32'(rise_cnt[3]), 32'd1);
        hold(4'h0, 7);

        // Glitch of two cycles is rejected.
        clear_log();
        hold(4'h1, 2);
        hold(4'h0, 7);
        check("glitch_raw_width", 32'(raw_hi[0]), 32'd2);
        check("glitch_no_rise", 32'(rise_cnt[0]), 32'd0);

        // Exactly FILTER_LEN cycles passes; fall follows FILTER_LEN edges later.
        clear_log();
        hold(4'h1, 3);
        hold(4'h0, 8);
        check("minpass_rise_cnt", 32'(rise_cnt[0]), 32'd1);
        check("minpass_fall_gap", 32'(last_fall[0] - last_rise[0]), 32'd3);

        // Simultaneous rise and fall on different channels.
        hold(4'b0100, 7);
        clear_log();
        hold(4'b0010, 7);
        check("simul_rise_vec", 32'(first_rise_vec), 32'b0010);
        check("simul_fall_vec", 32'(first_fall_vec), 32'b0100);
        hold(4'h0, 7);

        // Reset mid-count discards the partial count.
        clear_log();
        hold(4'h8, 4);
        cycle(4'h8, 1'b1);
        cycle(4'h8, 1'b0);
        rel_edge = edge_n;
        hold(4'h8, 7);
        check("midreset_rise_latency", 32'(last_rise[3] - rel_edge + 1), 32'd5);
        check("midreset_rise_cnt", 32'(rise_cnt[3]), 32'd1);
        hold(4'h0, 7);

        // Chatter: 1,1,0,1,1,1 yields one rise timed from the final run.
        clear_log();
        base_edge = edge_n;
        cycle(4'h2, 1'b0);
        cycle(4'h2, 1'b0);
        cycle(4'h0, 1'b0);
        cycle(4'h2, 1'b0);
        run_edge = edge_n;
        cycle(4'h2, 1'b0);
        cycle(4'h2, 1'b0);
        hold(4'h2, 5);
        check("chatter_rise_cnt", 32'(rise_cnt[1]), 32'd1);
        check("chatter_rise_latency", 32'(last_rise[1] - run_edge + 1), 32'd5);
        hold(4'h0, 7);

        // Random tail scored by the model only.
        for (int i = 0; i < 200; i++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0));
        end
        hold(4'h0, 8);
        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
